// File: rtl/tsc.sv
// tsc -- triggered sample capture with serial read-out.
//
// An internal ADC model produces an 8-bit ramp, one sample every two clocks,
// into a 32-entry ring buffer. Once a sample reaches TRIG_LEVEL the block
// captures POST_SAMPLES more samples, then freezes the buffer and raises TRD_out.
// On SBF the whole buffer is shifted out LSB-first on SD_out, starting from
// the oldest entry. CD_out then pulses for one cycle and the block returns to IDLE.
//
// ADC handshake: in RUNNING/TRIGGERED, adc_request_out and adc_ready_out are
// never high together. A request cycle is always followed by a ready cycle.
// During the ready cycle adc_data_out holds the new sample. The edge that
// ends the ready cycle writes that sample to mem[write_ptr_out] and advances
// write_ptr_out. Both strobes are 0 in every other state.
//
// Optional feature: define TSC_TIMESTAMP_EN to include the free-running
// 32-bit timer and latch it into TRIGTM_out on the trigger edge. Without the
// macro the timer is not built and TRIGTM_out is constant 0.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start, SBF              one-cycle arm / send-buffer pulses
//   state_out               FSM state (IDLE=0 .. SENDING=4)
//   adc_request_out, adc_ready_out, adc_data_out    ADC handshake and sample
//   read_ptr_out, write_ptr_out                     ring-buffer pointers
//   ring_buffer_read_ptr, ring_buffer_write_ptr     mem at those pointers
//   remaining_values_out    post-trigger samples still to capture
//   TRIGTM_out              timer value latched at trigger
//   TRD_out, SD_out, CD_out buffer ready, serial data, send complete
//   serial_bit_out          index of the bit currently on SD_out
module tsc #(
  parameter logic [7:0] TRIG_LEVEL   = 8'd200,
  parameter int         POST_SAMPLES = 16,
  parameter logic [7:0] ADC_STEP     = 8'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        SBF,
  output logic [2:0]  state_out,
  output logic        adc_request_out,
  output logic        adc_ready_out,
  output logic [7:0]  adc_data_out,
  output logic [4:0]  read_ptr_out,
  output logic [4:0]  write_ptr_out,
  output logic [7:0]  ring_buffer_read_ptr,
  output logic [7:0]  ring_buffer_write_ptr,
  output logic [4:0]  remaining_values_out,
  output logic [31:0] TRIGTM_out,
  output logic        TRD_out,
  output logic        SD_out,
  output logic        CD_out,
  output logic [3:0]  serial_bit_out
);

  localparam logic [4:0] POST_CNT = 5'(POST_SAMPLES);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RUNNING      = 3'd1,
    TRIGGERED    = 3'd2,
    BUFFER_READY = 3'd3,
    SENDING      = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] mem [32];
  logic [4:0] send_byte;
  logic       capturing;
  logic       mem_we;
  logic       trig_evt;

  assign capturing = (state == RUNNING) || (state == TRIGGERED);
  // A sample is committed at the edge that ends its ready cycle.
  assign mem_we    = capturing && adc_ready_out;
  assign trig_evt  = (state == RUNNING) && adc_ready_out && (adc_data_out >= TRIG_LEVEL);

  assign state_out             = state;
  assign ring_buffer_read_ptr  = mem[read_ptr_out];
  assign ring_buffer_write_ptr = mem[write_ptr_out];
  assign SD_out                = (state == SENDING) ? mem[read_ptr_out][serial_bit_out[2:0]] : 1'b0;

  // Buffer storage has no reset; its contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[write_ptr_out] <= adc_data_out;
  end

`ifdef TSC_TIMESTAMP_EN
  logic [31:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer <= 32'd0;
    else       timer <= timer + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         TRIGTM_out <= 32'd0;
    else if (trig_evt) TRIGTM_out <= timer;
  end
`else
  assign TRIGTM_out = 32'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      adc_request_out      <= 1'b0;
      adc_ready_out        <= 1'b0;
      adc_data_out         <= 8'd0;
      write_ptr_out        <= 5'd0;
      read_ptr_out         <= 5'd0;
      remaining_values_out <= 5'd0;
      TRD_out              <= 1'b0;
      CD_out               <= 1'b0;
      serial_bit_out       <= 4'd0;
      send_byte            <= 5'd0;
    end else begin
      CD_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= RUNNING;
            adc_request_out <= 1'b1;
            adc_ready_out   <= 1'b0;
          end
        end

        RUNNING, TRIGGERED: begin
          if (adc_request_out) begin
            adc_request_out <= 1'b0;
            adc_ready_out   <= 1'b1;
            adc_data_out    <= adc_data_out + ADC_STEP;
          end else begin
            adc_ready_out   <= 1'b0;
            adc_request_out <= 1'b1;
            if (adc_ready_out) begin
              write_ptr_out <= write_ptr_out + 5'd1;
              if (state == RUNNING) begin
                if (trig_evt) begin
                  state                <= TRIGGERED;
                  remaining_values_out <= POST_CNT;
                end
              end else begin
                remaining_values_out <= remaining_values_out - 5'd1;
                if (remaining_values_out == 5'd1) begin
                  // Last post-trigger sample: the slot after it is the oldest.
                  state           <= BUFFER_READY;
                  TRD_out         <= 1'b1;
                  read_ptr_out    <= write_ptr_out + 5'd1;
                  adc_request_out <= 1'b0;
                end
              end
            end
          end
        end

        BUFFER_READY: begin
          if (SBF) begin
            state          <= SENDING;
            serial_bit_out <= 4'd0;
            send_byte      <= 5'd0;
          end else if (start) begin
            state           <= RUNNING;
            TRD_out         <= 1'b0;
            adc_request_out <= 1'b1;
            adc_ready_out   <= 1'b0;
          end
        end

        SENDING: begin
          if (serial_bit_out == 4'd7) begin
            serial_bit_out <= 4'd0;
            read_ptr_out   <= read_ptr_out + 5'd1;
            if (send_byte == 5'd31) begin
              state   <= IDLE;
              CD_out  <= 1'b1;
              TRD_out <= 1'b0;
            end else begin
              send_byte <= send_byte + 5'd1;
            end
          end else begin
            serial_bit_out <= serial_bit_out + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsc.sv
module tb_tsc;

  localparam logic [7:0] TRIG_LEVEL   = 8'd200;
  localparam int         POST_SAMPLES = 16;
  localparam logic [7:0] ADC_STEP     = 8'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        SBF;
  logic [2:0]  state_out;
  logic        adc_request_out;
  logic        adc_ready_out;
  logic [7:0]  adc_data_out;
  logic [4:0]  read_ptr_out;
  logic [4:0]  write_ptr_out;
  logic [7:0]  ring_buffer_read_ptr;
  logic [7:0]  ring_buffer_write_ptr;
  logic [4:0]  remaining_values_out;
  logic [31:0] TRIGTM_out;
  logic        TRD_out;
  logic        SD_out;
  logic        CD_out;
  logic [3:0]  serial_bit_out;

  tsc #(
    .TRIG_LEVEL  (TRIG_LEVEL),
    .POST_SAMPLES(POST_SAMPLES),
    .ADC_STEP    (ADC_STEP)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .SBF                  (SBF),
    .state_out            (state_out),
    .adc_request_out      (adc_request_out),
    .adc_ready_out        (adc_ready_out),
    .adc_data_out         (adc_data_out),
    .read_ptr_out         (read_ptr_out),
    .write_ptr_out        (write_ptr_out),
    .ring_buffer_read_ptr (ring_buffer_read_ptr),
    .ring_buffer_write_ptr(ring_buffer_write_ptr),
    .remaining_values_out (remaining_values_out),
    .TRIGTM_out           (TRIGTM_out),
    .TRD_out              (TRD_out),
    .SD_out               (SD_out),
    .CD_out               (CD_out),
    .serial_bit_out       (serial_bit_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc;        // clock edges since reset release (timer model)
  int          k_glob;     // ADC samples produced since reset
  int          wp_m;
  int          rp_m;
  logic [31:0] trigtm_m;
  logic [7:0]  mem_m [32];
  logic [7:0]  exp_q [$];  // bytes expected on the serial line, oldest first

  // Sample k since reset is simply k*ADC_STEP modulo 256.
  function automatic logic [7:0] ramp(input int k);
    logic [31:0] p;
    p = k * ADC_STEP;
    return p[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic req,
                         input logic rdy, input logic [7:0] data, input int wp,
                         input int rp, input int rem, input logic [31:0] tt,
                         input logic trd, input logic sd, input logic cd,
                         input int sbit);
    chk({tag, ".state"}, state_out, st);
    chk({tag, ".req"},   adc_request_out, req);
    chk({tag, ".rdy"},   adc_ready_out, rdy);
    chk({tag, ".data"},  adc_data_out, data);
    chk({tag, ".wp"},    write_ptr_out, wp);
    chk({tag, ".rp"},    read_ptr_out, rp);
    chk({tag, ".rem"},   remaining_values_out, rem);
    chk({tag, ".trigtm"}, TRIGTM_out, tt);
    chk({tag, ".trd"},   TRD_out, trd);
    chk({tag, ".sd"},    SD_out, sd);
    chk({tag, ".cd"},    CD_out, cd);
    chk({tag, ".bit"},   serial_bit_out, sbit);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse(input logic s, input logic b);
    start = s;
    SBF   = b;
    step();
    start = 1'b0;
    SBF   = 1'b0;
  endtask

  // Runs one capture after the arming edge; sample timing is derived from
  // the sample index: request on even observations, ready on odd ones.
  task automatic capture(input string tag);
    int          j_trig;
    int          j_end;
    int          k0;
    int          wp0;
    int          cyc0;
    int          n;
    int          rem_e;
    logic [2:0]  st_e;
    logic [31:0] tt_e;
    string       tg;
    k0     = k_glob;
    wp0    = wp_m;
    cyc0   = cyc;
    j_trig = 0;
    for (int j = 1; j <= 300 && j_trig == 0; j++)
      if (ramp(k0 + j) >= TRIG_LEVEL) j_trig = j;
    j_end = j_trig + POST_SAMPLES;
`ifdef TSC_TIMESTAMP_EN
    tt_e = 32'(cyc0 + 2 * j_trig - 1);
`else
    tt_e = 32'd0;
`endif
    for (int t = 0; t < 2 * j_end; t++) begin
      n     = t / 2;
      st_e  = (n < j_trig) ? 3'd1 : 3'd2;
      rem_e = (n < j_trig) ? 0 : POST_SAMPLES - (n - j_trig);
      tg    = $sformatf("%s.t%0d", tag, t);
      chk_all(tg, st_e, (t % 2) == 0, (t % 2) == 1, ramp(k0 + (t + 1) / 2),
              (wp0 + n) % 32, rp_m, rem_e, (n < j_trig) ? trigtm_m : tt_e,
              1'b0, 1'b0, 1'b0, 0);
      // Stray start/SBF pulses while capturing must have no effect.
      pulse($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
    for (int j = 1; j <= j_end; j++) mem_m[(wp0 + j - 1) % 32] = ramp(k0 + j);
    k_glob   = k0 + j_end;
    wp_m     = (wp0 + j_end) % 32;
    rp_m     = wp_m;
    trigtm_m = tt_e;
    chk_all({tag, ".done"}, 3'd3, 1'b0, 1'b0, ramp(k_glob), wp_m, rp_m, 0,
            trigtm_m, 1'b1, 1'b0, 1'b0, 0);
    chk({tag, ".rbrd"}, ring_buffer_read_ptr, mem_m[rp_m]);
  endtask

  task automatic br_wait(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      chk_all($sformatf("%s.w%0d", tag, i), 3'd3, 1'b0, 1'b0, ramp(k_glob), wp_m,
              rp_m, 0, trigtm_m, 1'b1, 1'b0, 1'b0, 0);
      chk({tag, ".rbrd"}, ring_buffer_read_ptr, mem_m[rp_m]);
      chk({tag, ".rbwr"}, ring_buffer_write_ptr, mem_m[wp_m]);
    end
  endtask

  // Sends the frozen buffer; returns early (without stepping) at abort_at.
  task automatic send(input string tag, input int abort_at, input logic with_start);
    logic [7:0] byte_e;
    string      tg;
    exp_q.delete();
    for (int b = 0; b < 32; b++) exp_q.push_back(mem_m[(rp_m + b) % 32]);
    pulse(with_start, 1'b1);
    byte_e = exp_q.pop_front();
    for (int t = 0; t < 256; t++) begin
      tg = $sformatf("%s.t%0d", tag, t);
      chk_all(tg, 3'd4, 1'b0, 1'b0, ramp(k_glob), wp_m, (rp_m + t / 8) % 32, 0,
              trigtm_m, 1'b1, byte_e[t % 8], 1'b0, t % 8);
      chk({tg, ".rbrd"}, ring_buffer_read_ptr, byte_e);
      if (t == abort_at) return;
      step();
      if ((t % 8) == 7 && t != 255) byte_e = exp_q.pop_front();
    end
    chk_all({tag, ".end"}, 3'd0, 1'b0, 1'b0, ramp(k_glob), wp_m, rp_m, 0,
            trigtm_m, 1'b0, 1'b0, 1'b1, 0);
    step();
    chk_all({tag, ".post"}, 3'd0, 1'b0, 1'b0, ramp(k_glob), wp_m, rp_m, 0,
            trigtm_m, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic model_reset();
    cyc      = 0;
    k_glob   = 0;
    wp_m     = 0;
    rp_m     = 0;
    trigtm_m = 32'd0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    SBF   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 3'd0, 1'b0, 1'b0, 8'd0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    model_reset();

    // SBF in IDLE is ignored.
    for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
      pulse(1'b0, 1'($urandom_range(0, 1)));
      chk_all("idle", 3'd0, 1'b0, 1'b0, 8'd0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
    end

    pulse(1'b1, 1'b0);
    capture("cap1");
    br_wait("br1", $urandom_range(1, 4));

    // Re-arm: ramp continues from its last value.
    pulse(1'b1, 1'b0);
    capture("cap2");
    br_wait("br2", $urandom_range(0, 3));

    // start and SBF together: SBF wins.
    send("send1", 999, 1'b1);

    pulse(1'b1, 1'b0);
    capture("cap3");
    send("send2", $urandom_range(10, 250), 1'b0);

    // Reset in the middle of sending aborts at once, without CD_out.
    #2;
    reset = 1'b1;
    #1;
    chk_all("abort", 3'd0, 1'b0, 1'b0, 8'd0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("abort.c%0d", i), 3'd0, 1'b0, 1'b0, 8'd0, 0, 0, 0, 32'd0,
              1'b0, 1'b0, 1'b0, 0);
    end
    reset = 1'b0;
    model_reset();

    pulse(1'b1, 1'b0);
    capture("cap4");
    br_wait("br4", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
